jt12_status_unit: RTL and testbench
===================================

// Module: jt12_status_unit
// PURPOSE
//  Status/readback unit for the JT12-family FM cores. It generalises the plain read multiplexer:
//  - sticky timer flags and sticky ADPCM end flags, with set/clear arbitration
//  - a write-busy down-counter and an IRQ-enable mask driving irq_n
//  - a registered CPU read port whose map is selected by MODE: YM2203, YM2608 or YM2610
//  Sits between the timer/ADPCM engines and the CPU bus wrapper.
// PARAMETERS
//  MODE        0  read map: 0=YM2203, 1=YM2608, 2=YM2610
//  USE_SSG     1  1: addr 1 returns psg_dout; 0: addr 1 mirrors status
//  USE_CHIPID  0  1: addr 1 returns CHIPID while sel_chipid=1
//  CHIPID      8'h01  value returned as chip ID
//  BUSY_CYC    32  busy duration, counted in cen cycles (1..255)
//  NA          6  number of ADPCM-A channel end flags (1..6)
// PORTS
//  rst          in   1   synchronous reset, active-high
//  clk          in   1   CPU clock
//  cen          in   1   clock enable for the busy counter
//  wr           in   1   one-cycle CPU write strobe (any address)
//  addr         in   2   CPU read address
//  sel_chipid   in   1   chip-ID select for addr 1
//  tim_set      in   2   {B,A} timer overflow pulses
//  tim_clr      in   2   {B,A} flag reset from timer control write
//  tim_irqen    in   2   {B,A} IRQ enable for the timer flags
//  pcma_end     in   NA  ADPCM-A channel end pulses
//  pcmb_end     in   1   ADPCM-B end pulse
//  pcm_clr      in   NA+1  {B,A[NA-1:0]} flag reset from flag-control write
//  pcm_mask     in   NA+1  {B,A[NA-1:0]} 1 = suppress setting and IRQ
//  pcmb_brdy    in   1   ADPCM-B buffer-ready level; live, not sticky
//  psg_dout     in   8   SSG register read data
//  dout_b       in   8   ADPCM-B memory read data
//  busy         out  1   write busy
//  irq_n        out  1   interrupt, active-low
//  dout         out  8   registered read data
// BEHAVIOUR
//  Reset values: busy=0, counter=0, every sticky flag=0, irq_n=1, dout=8'h00.
//  Busy
//  - wr loads cnt with BUSY_CYC; busy=(cnt!=0).
//  - cnt decrements on every cen while nonzero.
//  - wr during busy reloads cnt; wr and cen in the same cycle: the load wins.
//  - busy rises on the cycle after wr and stays high for exactly BUSY_CYC cen pulses.
//  Sticky flags (flgA, flgB, pa[NA-1:0], pb)
//  - a flag sets on its pulse and holds until its clear bit is asserted.
//  - set and clear in the same cycle: set wins.
//  - pa/pb do not set while the matching pcm_mask bit is 1.
//  - raising a mask bit does not clear a flag that is already set.
//  IRQ
//  - irq_n is registered: ~|({flgB,flgA}&tim_irqen | {pb,pa}&~pcm_mask).
//  - it reflects flag state one cycle after the flag register update (2 clk after the pulse).
//  Read map, dout registered each clk: 1 clk latency from addr, no read side-effects.
//  - addr0: {busy,5'd0,flgB,flgA}
//  - addr1: USE_CHIPID&sel_chipid ? CHIPID : USE_SSG ? psg_dout : addr0 value
//  - addr2, MODE0: addr0 value
//  - addr2, MODE1: {busy,1'b0,pcmb_brdy,pb,2'b0,flgB,flgA}
//  - addr2, MODE2: {pb,1'b0,pa zero-extended to 6 bits}
//  - addr3, MODE0: addr0 value
//  - addr3, MODE1: dout_b
//  - addr3, MODE2: same as addr2
//  - unused pa bits (NA<6) read 0.
//  rst mid-operation: counter and all flags clear on the next edge; pulses in the rst cycle are lost.
// TESTING
//  - reset: rst 1 clk -> dout=00, busy=0, irq_n=1 after release.
//  - busy: BUSY_CYC=4, cen every 2nd clk, wr -> busy high for exactly 4 cen (8 clk).
//    A second wr mid-way -> busy extends 4 cen from that wr.
//  - timer A: tim_irqen=01, tim_set=01 pulse -> addr0 reads 8'h01, irq_n=0.
//    tim_set=01 with tim_clr=01 in the same clk -> flag stays 1.
//    tim_clr=01 alone -> 8'h00, irq_n=1.
//  - MODE2, NA=6: pcma_end=6'b100001 -> addr2 reads 8'h21, irq_n=0.
//    pcm_mask=7'b0000001 then pcma_end[0] pulse -> pa[0] does not set.
//  - MODE1: pcmb_end then read addr2 with busy=1, brdy=1 -> 8'hB0.
//    dout_b=8'h5A at addr3 -> 8'h5A one clk later.
//  - USE_CHIPID=1: sel_chipid=1 at addr1 -> 8'h01; sel_chipid=0 -> psg_dout.

Source files
------------

// File: rtl/jt12_status_unit_if.sv
// CPU-side bus of the JT12 status unit: write strobe, read address and readback.
interface jt12_status_unit_if;
    logic       wr;
    logic [1:0] addr;
    logic       sel_chipid;
    logic       busy;
    logic       irq_n;
    logic [7:0] dout;

    modport master (output wr, addr, sel_chipid, input busy, irq_n, dout);
    modport slave  (input wr, addr, sel_chipid, output busy, irq_n, dout);
endinterface

// File: rtl/jt12_status_unit.sv
// Status/readback unit for JT12-family FM cores: sticky timer/ADPCM flags,
// write-busy counter, IRQ generation and a chip-dependent registered read map.
module jt12_status_unit #(
    parameter int         MODE       = 0,
    parameter int         USE_SSG    = 1,
    parameter int         USE_CHIPID = 0,
    parameter logic [7:0] CHIPID     = 8'h01,
    parameter int         BUSY_CYC   = 32,
    parameter int         NA         = 6
) (
    input  logic                rst,
    input  logic                clk,
    input  logic                cen,
    jt12_status_unit_if.slave   bus,
    input  logic [1:0]          tim_set,
    input  logic [1:0]          tim_clr,
    input  logic [1:0]          tim_irqen,
    input  logic [NA-1:0]       pcma_end,
    input  logic                pcmb_end,
    input  logic [NA:0]         pcm_clr,
    input  logic [NA:0]         pcm_mask,
    input  logic                pcmb_brdy,
    input  logic [7:0]          psg_dout,
    input  logic [7:0]          dout_b
);

    localparam logic [7:0] BUSY_LD = 8'(BUSY_CYC);

    logic [7:0]    cnt;
    logic [1:0]    flg;      // {flgB, flgA}
    logic [NA-1:0] pa;
    logic          pb;
    logic          irq_n_q;
    logic [7:0]    dout_q;

    logic [5:0]    pa6;
    logic [7:0]    st0;
    logic [7:0]    rd;

    assign bus.busy  = (cnt != 8'd0);
    assign bus.irq_n = irq_n_q;
    assign bus.dout  = dout_q;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        pa6         = '0;
        pa6[NA-1:0] = pa;
        st0         = {bus.busy, 5'd0, flg};
        rd          = st0;
        case (bus.addr)
            2'd1: begin
                if (USE_CHIPID != 0 && bus.sel_chipid) rd = CHIPID;
                else if (USE_SSG != 0)                 rd = psg_dout;
            end
            2'd2: begin
                if (MODE == 1)      rd = {bus.busy, 1'b0, pcmb_brdy, pb, 2'b00, flg};
                else if (MODE == 2) rd = {pb, 1'b0, pa6};
            end
            2'd3: begin
                if (MODE == 1)      rd = dout_b;
                else if (MODE == 2) rd = {pb, 1'b0, pa6};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 8'd0;
            flg     <= 2'b00;
            pa      <= '0;
            pb      <= 1'b0;
            irq_n_q <= 1'b1;
            dout_q  <= 8'h00;
        end else begin
            // A write reloads the counter even if cen arrives in the same cycle.
            if (bus.wr)                  cnt <= BUSY_LD;
            else if (cen && cnt != 8'd0) cnt <= cnt - 8'd1;

            // Set beats clear; masks only block new sets.
            flg <= (flg & ~tim_clr) | tim_set;
            pa  <= (pa & ~pcm_clr[NA-1:0]) | (pcma_end & ~pcm_mask[NA-1:0]);
            pb  <= (pb & ~pcm_clr[NA]) | (pcmb_end & ~pcm_mask[NA]);

            irq_n_q <= ~(|(flg & tim_irqen) | |({pb, pa} & ~pcm_mask));
            dout_q  <= rd;
        end
    end

endmodule

// File: tb/tb_jt12_status_unit.sv
// Directed bench for jt12_status_unit: a MODE1/chip-ID instance and a MODE2 instance.
module tb_jt12_status_unit;
    logic       clk = 1'b0;
    logic       rst, cen, wr, sel_chipid, pcmb_end, pcmb_brdy;
    logic [1:0] addr, tim_set, tim_clr, tim_irqen;
    logic [5:0] pcma_end;
    logic [6:0] pcm_clr, pcm_mask;
    logic [7:0] psg_dout, dout_b;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jt12_status_unit_if bus_a ();
    jt12_status_unit_if bus_b ();
    assign bus_a.wr = wr;  assign bus_a.addr = addr;  assign bus_a.sel_chipid = sel_chipid;
    assign bus_b.wr = wr;  assign bus_b.addr = addr;  assign bus_b.sel_chipid = sel_chipid;

    jt12_status_unit #(.MODE(1), .USE_SSG(1), .USE_CHIPID(1), .CHIPID(8'h01), .BUSY_CYC(4), .NA(6))
    dut_a (.rst(rst), .clk(clk), .cen(cen), .bus(bus_a), .tim_set(tim_set), .tim_clr(tim_clr),
           .tim_irqen(tim_irqen), .pcma_end(pcma_end), .pcmb_end(pcmb_end), .pcm_clr(pcm_clr),
           .pcm_mask(pcm_mask), .pcmb_brdy(pcmb_brdy), .psg_dout(psg_dout), .dout_b(dout_b));

    jt12_status_unit #(.MODE(2), .USE_SSG(1), .USE_CHIPID(0), .CHIPID(8'h01), .BUSY_CYC(4), .NA(6))
    dut_b (.rst(rst), .clk(clk), .cen(cen), .bus(bus_b), .tim_set(tim_set), .tim_clr(tim_clr),
           .tim_irqen(tim_irqen), .pcma_end(pcma_end), .pcmb_end(pcmb_end), .pcm_clr(pcm_clr),
           .pcm_mask(pcm_mask), .pcmb_brdy(pcmb_brdy), .psg_dout(psg_dout), .dout_b(dout_b));

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (bus_a.dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", bus_a.dout); end
        n_cmp++; if (bus_a.busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
        n_cmp++; if (bus_a.irq_n !== 1'b1) begin n_bad++; $display("FAIL reset_irq_n: got %b want 1", bus_a.irq_n); end
        tick();
        n_cmp++; if (bus_b.dout !== 8'h00) begin n_bad++; $display("FAIL reset_read0: got %h want 00", bus_b.dout); end
    endtask

    task automatic test_busy();
        wr = 1'b1; cen = 1'b0;
        tick();
        wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL busy_high[%0d]: got %b want 1", i, bus_a.busy); end
            cen = i[0];
            tick();
        end
        cen = 1'b0;
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL busy_end: got %b want 0", bus_a.busy); end
        // wr with cen in the same cycle, then a reload after two cen pulses
        wr = 1'b1; cen = 1'b1;
        tick();
        wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cen = i[0];
            tick();
        end
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL busy_mid: got %b want 1", bus_a.busy); end
        wr = 1'b1; cen = 1'b1;
        tick();
        wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL busy_ext[%0d]: got %b want 1", i, bus_a.busy); end
            cen = i[0];
            tick();
        end
        cen = 1'b0;
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL busy_ext_end: got %b want 0", bus_a.busy); end
    endtask

    task automatic test_timer();
        addr = 2'd0; tim_irqen = 2'b01;
        tim_set = 2'b01; tick(); tim_set = 2'b00;
        n_cmp++; if (bus_a.irq_n !== 1'b1) begin n_bad++; $display("FAIL tim_irq_latency: got %b want 1", bus_a.irq_n); end
        tick();
        n_cmp++; if (bus_a.dout !== 8'h01) begin n_bad++; $display("FAIL tim_a_set: got %h want 01", bus_a.dout); end
        n_cmp++; if (bus_a.irq_n !== 1'b0) begin n_bad++; $display("FAIL tim_a_irq: got %b want 0", bus_a.irq_n); end
        tim_set = 2'b01; tim_clr = 2'b01; tick(); tim_set = 2'b00; tim_clr = 2'b00; tick();
        n_cmp++; if (bus_a.dout !== 8'h01) begin n_bad++; $display("FAIL tim_set_wins: got %h want 01", bus_a.dout); end
        tim_clr = 2'b01; tick(); tim_clr = 2'b00; tick();
        n_cmp++; if (bus_a.dout !== 8'h00) begin n_bad++; $display("FAIL tim_a_clr: got %h want 00", bus_a.dout); end
        n_cmp++; if (bus_a.irq_n !== 1'b1) begin n_bad++; $display("FAIL tim_a_clr_irq: got %b want 1", bus_a.irq_n); end
        tim_set = 2'b10; tick(); tim_set = 2'b00; tick();
        n_cmp++; if (bus_a.dout !== 8'h02) begin n_bad++; $display("FAIL tim_b_set: got %h want 02", bus_a.dout); end
        n_cmp++; if (bus_a.irq_n !== 1'b1) begin n_bad++; $display("FAIL tim_b_disabled_irq: got %b want 1", bus_a.irq_n); end
        tim_clr = 2'b11; tick(); tim_clr = 2'b00; tick();
        n_cmp++; if (bus_a.dout !== 8'h00) begin n_bad++; $display("FAIL tim_b_clr: got %h want 00", bus_a.dout); end
    endtask

    task automatic test_mode2();
        addr = 2'd2; pcm_mask = 7'b0;
        pcma_end = 6'b100001; tick(); pcma_end = 6'b0; tick();
        n_cmp++; if (bus_b.dout !== 8'h21) begin n_bad++; $display("FAIL m2_pa_set: got %h want 21", bus_b.dout); end
        n_cmp++; if (bus_b.irq_n !== 1'b0) begin n_bad++; $display("FAIL m2_pa_irq: got %b want 0", bus_b.irq_n); end
        pcm_clr = 7'h7F; tick(); pcm_clr = 7'h00; tick();
        n_cmp++; if (bus_b.dout !== 8'h00) begin n_bad++; $display("FAIL m2_pa_clr: got %h want 00", bus_b.dout); end
        n_cmp++; if (bus_b.irq_n !== 1'b1) begin n_bad++; $display("FAIL m2_pa_clr_irq: got %b want 1", bus_b.irq_n); end
        pcm_mask = 7'b0000001;
        pcma_end = 6'b000001; tick(); pcma_end = 6'b0; tick();
        n_cmp++; if (bus_b.dout !== 8'h00) begin n_bad++; $display("FAIL m2_mask_blocks: got %h want 00", bus_b.dout); end
        n_cmp++; if (bus_b.irq_n !== 1'b1) begin n_bad++; $display("FAIL m2_mask_irq: got %b want 1", bus_b.irq_n); end
        pcma_end = 6'b000010; tick(); pcma_end = 6'b0;
        pcm_mask = 7'b0000011; tick(); tick();
        n_cmp++; if (bus_b.dout !== 8'h02) begin n_bad++; $display("FAIL m2_mask_keeps: got %h want 02", bus_b.dout); end
        n_cmp++; if (bus_b.irq_n !== 1'b1) begin n_bad++; $display("FAIL m2_mask_keeps_irq: got %b want 1", bus_b.irq_n); end
        pcmb_end = 1'b1; tick(); pcmb_end = 1'b0; tick();
        n_cmp++; if (bus_b.dout !== 8'h82) begin n_bad++; $display("FAIL m2_pb_set: got %h want 82", bus_b.dout); end
        n_cmp++; if (bus_b.irq_n !== 1'b0) begin n_bad++; $display("FAIL m2_pb_irq: got %b want 0", bus_b.irq_n); end
        pcm_mask = 7'b0; pcm_clr = 7'h7F; tick(); pcm_clr = 7'h00; tick();
        n_cmp++; if (bus_b.dout !== 8'h00) begin n_bad++; $display("FAIL m2_all_clr: got %h want 00", bus_b.dout); end
    endtask

    task automatic test_mode1();
        pcmb_end = 1'b1; tick(); pcmb_end = 1'b0;
        wr = 1'b1; pcmb_brdy = 1'b1; addr = 2'd2; tick();
        wr = 1'b0; tick();
        n_cmp++; if (bus_a.dout !== 8'hB0) begin n_bad++; $display("FAIL m1_addr2: got %h want b0", bus_a.dout); end
        addr = 2'd3; dout_b = 8'h5A; tick();
        n_cmp++; if (bus_a.dout !== 8'h5A) begin n_bad++; $display("FAIL m1_addr3: got %h want 5a", bus_a.dout); end
    endtask

    task automatic test_rst_mid();
        pcmb_brdy = 1'b0;
        rst = 1'b1; pcma_end = 6'b000011; tim_set = 2'b01; tick();
        rst = 1'b0; pcma_end = 6'b0; tim_set = 2'b00;
        n_cmp++; if (bus_a.busy !== 1'b0)  begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", bus_a.busy); end
        n_cmp++; if (bus_a.irq_n !== 1'b1) begin n_bad++; $display("FAIL rst_mid_irq: got %b want 1", bus_a.irq_n); end
        addr = 2'd2; tick(); tick();
        n_cmp++; if (bus_b.dout !== 8'h00) begin n_bad++; $display("FAIL rst_mid_flags: got %h want 00", bus_b.dout); end
        n_cmp++; if (bus_a.dout !== 8'h00) begin n_bad++; $display("FAIL rst_mid_m1: got %h want 00", bus_a.dout); end
        n_cmp++; if (bus_a.irq_n !== 1'b1) begin n_bad++; $display("FAIL rst_mid_irq2: got %b want 1", bus_a.irq_n); end
    endtask

    task automatic test_chipid();
        addr = 2'd1; sel_chipid = 1'b1; psg_dout = 8'hC3; tick();
        n_cmp++; if (bus_a.dout !== 8'h01) begin n_bad++; $display("FAIL chipid_sel: got %h want 01", bus_a.dout); end
        n_cmp++; if (bus_b.dout !== 8'hC3) begin n_bad++; $display("FAIL chipid_off_psg: got %h want c3", bus_b.dout); end
        sel_chipid = 1'b0; tick();
        n_cmp++; if (bus_a.dout !== 8'hC3) begin n_bad++; $display("FAIL chipid_psg: got %h want c3", bus_a.dout); end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; wr = 1'b0; sel_chipid = 1'b0; addr = 2'd0;
        tim_set = 2'b0; tim_clr = 2'b0; tim_irqen = 2'b0;
        pcma_end = 6'b0; pcmb_end = 1'b0; pcm_clr = 7'b0; pcm_mask = 7'b0;
        pcmb_brdy = 1'b0; psg_dout = 8'h00; dout_b = 8'h00;
        test_reset();
        test_busy();
        test_timer();
        test_mode2();
        test_mode1();
        test_rst_mid();
        test_chipid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
